cpu_sram2like: RTL and testbench

//  Converts the CPU data-port SRAM interface (en/wen/addr/wdata -> rdata) into the sram-like

---
 rtl/cpu_sram2like.sv | 89 ++++++++
 tb/tb_cpu_sram2like.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sram2like.sv
// cpu_sram2like: CPU SRAM port to sram-like handshake adapter with pipeline stall and read-data hold.
// Define CPU_SRAM2LIKE_POSTED_WR_EN to let writes complete for the CPU at addr_ok.
module cpu_sram2like #(
    parameter bit READ_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        cpu_hold,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wen,
    input  logic [31:0] rdata,
    input  logic        addr_ok,
    input  logic        data_ok
);
`ifdef CPU_SRAM2LIKE_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, state_nx;
    logic   pending, start, accept, capture, post;

    function automatic logic [1:0] size_of(input logic [3:0] w);
        return (w == 4'b0001 || w == 4'b0010 || w == 4'b0100 || w == 4'b1000) ? 2'd0 :
               (w == 4'b0011 || w == 4'b1100) ? 2'd1 : 2'd2;
    endfunction

    always_comb begin
        start     = state == IDLE && cpu_en && !pending;
        accept    = state == REQ && addr_ok;
        capture   = (accept || state == WAIT) && data_ok;
        post      = POSTED && accept && wr;
        cpu_stall = state == IDLE ? cpu_en : state != DONE;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = start ? REQ : IDLE;
            REQ:     state_nx = accept ? ((capture || post) ? DONE : WAIT) : REQ;
            WAIT:    state_nx = data_ok ? DONE : WAIT;
            DONE:    state_nx = cpu_hold ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A posted write whose data_ok arrives with addr_ok never becomes pending.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            req       <= 1'b0;
            wr        <= 1'b0;
            size      <= 2'd0;
            addr      <= 32'd0;
            wdata     <= 32'd0;
            wen       <= 4'd0;
            cpu_rdata <= 32'd0;
            pending   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                req   <= 1'b1;
                wr    <= |cpu_wen;
                size  <= size_of(cpu_wen);
                addr  <= (|cpu_wen || !READ_ALIGN) ? cpu_addr : {cpu_addr[31:2], 2'b00};
                wdata <= cpu_wdata;
                wen   <= cpu_wen;
            end
            if (accept)
                req <= 1'b0;
            if (capture && !wr)
                cpu_rdata <= rdata;
            if (post && !data_ok)
                pending <= 1'b1;
            else if (data_ok)
                pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_sram2like.sv
// tb_cpu_sram2like: randomized self-checking bench for cpu_sram2like against a spec-level model.
// Posted-write scenario is compiled in when CPU_SRAM2LIKE_POSTED_WR_EN is defined.
module tb_cpu_sram2like;
`ifdef CPU_SRAM2LIKE_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn, cpu_en, cpu_hold, cpu_stall, req, wr, addr_ok, data_ok;
    logic [3:0]  cpu_wen, wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, addr, wdata, rdata;
    logic [1:0]  size;
    int          n_assert = 0;
    int          n_fail = 0;

    cpu_sram2like dut (
        .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_hold(cpu_hold),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .wen(wen),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_size(input logic [3:0] w);
        if ($countones(w) == 1) return 2'd0;
        if (w == 4'b0011 || w == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] m_addr(input logic [3:0] w, input logic [31:0] a);
        return w == 4'd0 ? a & ~32'h3 : a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0; cpu_en = 1'b0; cpu_hold = 1'b0; cpu_wen = '0; cpu_addr = '0;
        cpu_wdata = '0; rdata = '0; addr_ok = 1'b0; data_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Acts as the sram-like slave: addr_ok after aok_dly req cycles, data_ok dok_dly cycles
    // after the handshake cycle plus one (-1 = same cycle as addr_ok).
    task automatic run_access(input logic [3:0] w, input logic [31:0] a, d, rd,
                              input int aok_dly, dok_dly, output int n_hs, output int cycles,
                              output logic [31:0] f_addr, f_wdata, output logic [1:0] f_size,
                              output logic f_wr, output logic [3:0] f_wen, output bit stable);
        int hs_at, waited;
        bit seen;
        n_hs = 0; cycles = -1; hs_at = -1; waited = 0; seen = 0; stable = 1;
        f_addr = 'x; f_wdata = 'x; f_size = 'x; f_wr = 'x; f_wen = 'x;
        cpu_en = 1'b1; cpu_wen = w; cpu_addr = a; cpu_wdata = d;
        for (int c = 0; c < 40 && cycles < 0; c++) begin
            step();
            addr_ok = 1'b0; data_ok = 1'b0;
            if (req) begin
                if (!seen) begin
                    seen = 1; f_addr = addr; f_wdata = wdata; f_size = size; f_wr = wr; f_wen = wen;
                end else if ({addr, wdata, size, wr, wen} !== {f_addr, f_wdata, f_size, f_wr, f_wen})
                    stable = 0;
                if (waited >= aok_dly) begin
                    addr_ok = 1'b1; n_hs++;
                    if (hs_at < 0) hs_at = c;
                end
                waited++;
            end
            if (hs_at >= 0 && c == hs_at + 1 + dok_dly) begin
                data_ok = 1'b1; rdata = rd;
            end
            #1;
            if (!cpu_stall) cycles = c + 1;
        end
        cpu_en = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_assert++;
        if ({req, wr, size, addr, wdata, wen} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {req, wr, size, addr, wdata, wen});
        end
        n_assert++;
        if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        n_assert++;
        if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678;
        step(); step();
        addr_ok = 1'b0; data_ok = 1'b0;
        n_assert++;
        if ({req, cpu_rdata} !== 33'd0) begin
            n_fail++; $display("FAIL stray_handshake: got req=%b rdata=%h want 0/0", req, cpu_rdata);
        end
    endtask

    task automatic test_read_align();
        int nh, cy; logic [31:0] fa, fd; logic [1:0] fs; logic fw; logic [3:0] fe; bit st;
        apply_reset();
        run_access(4'd0, 32'h1000_0006, 32'h0, 32'hDEAD_BEEF, 0, 0, nh, cy, fa, fd, fs, fw, fe, st);
        n_assert++;
        if ({fa, fs, fw, fe} !== {32'h1000_0004, 2'd2, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL read_fields: got %h/%0d/%b/%b want 10000004/2/0/0000", fa, fs, fw, fe);
        end
        n_assert++;
        if (cy !== 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", cy); end
        n_assert++;
        if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", cpu_rdata); end
        n_assert++;
        if (nh !== 1) begin n_fail++; $display("FAIL read_handshakes: got %0d want 1", nh); end
    endtask

    task automatic test_write_sizes();
        logic [3:0] wt [8] = '{4'b0100, 4'b1100, 4'b1111, 4'b0101, 4'b0001, 4'b1000, 4'b0011, 4'b0110};
        logic [1:0] st_exp [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
        int nh, cy; logic [31:0] fa, fd; logic [1:0] fs; logic fw; logic [3:0] fe; bit st;
        for (int i = 0; i < 8; i++) begin
            apply_reset();
            run_access(wt[i], 32'h20 + i, 32'hA5A5_0000 + i, 32'hFFFF_FFFF, 0, 0, nh, cy, fa, fd, fs, fw, fe, st);
            n_assert++;
            if ({fs, fw, fe} !== {st_exp[i], 1'b1, wt[i]}) begin
                n_fail++; $display("FAIL write_size_%0d: got size=%0d wr=%b wen=%b want %0d/1/%b",
                                   i, fs, fw, fe, st_exp[i], wt[i]);
            end
            n_assert++;
            if ({fa, fd} !== {32'h20 + i, 32'hA5A5_0000 + i}) begin
                n_fail++; $display("FAIL write_addr_data_%0d: got %h %h", i, fa, fd);
            end
            n_assert++;
            if (cpu_rdata !== 32'd0 || nh !== 1) begin
                n_fail++; $display("FAIL write_side_%0d: got rdata=%h hs=%0d want 0/1", i, cpu_rdata, nh);
            end
        end
    endtask

    task automatic test_addr_ok_delay();
        int nh, cy; logic [31:0] fa, fd; logic [1:0] fs; logic fw; logic [3:0] fe; bit st;
        apply_reset();
        run_access(4'd0, 32'h0000_1236, 32'h0, 32'h0BAD_F00D, 5, 1, nh, cy, fa, fd, fs, fw, fe, st);
        n_assert++;
        if (st !== 1'b1) begin n_fail++; $display("FAIL delay_stable: fields changed while waiting"); end
        n_assert++;
        if (nh !== 1) begin n_fail++; $display("FAIL delay_handshakes: got %0d want 1", nh); end
        n_assert++;
        if (cy !== 9) begin n_fail++; $display("FAIL delay_latency: got %0d want 9", cy); end
        n_assert++;
        if ({fa, cpu_rdata} !== {32'h0000_1234, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL delay_data: got %h %h", fa, cpu_rdata);
        end
    endtask

    task automatic test_same_cycle();
        int nh, cy; logic [31:0] fa, fd; logic [1:0] fs; logic fw; logic [3:0] fe; bit st;
        apply_reset();
        run_access(4'd0, 32'h0000_0050, 32'h0, 32'h5A5A_1234, 0, -1, nh, cy, fa, fd, fs, fw, fe, st);
        n_assert++;
        if (cy !== 2 || cpu_rdata !== 32'h5A5A_1234) begin
            n_fail++; $display("FAIL same_cycle: got lat=%0d rdata=%h want 2/5a5a1234", cy, cpu_rdata);
        end
    endtask

    task automatic test_hold();
        int nh, cy; logic [31:0] fa, fd; logic [1:0] fs; logic fw; logic [3:0] fe; bit st;
        apply_reset();
        run_access(4'd0, 32'h40, 32'h0, 32'hCAFE_0001, 0, 0, nh, cy, fa, fd, fs, fw, fe, st);
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h40; cpu_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rdata = 32'h1111_1111 * (i + 2); data_ok = 1'b1;
            step();
            n_assert++;
            if ({req, cpu_stall, cpu_rdata} !== {2'b00, 32'hCAFE_0001}) begin
                n_fail++; $display("FAIL hold_%0d: got req=%b stall=%b rdata=%h want 0/0/cafe0001",
                                   i, req, cpu_stall, cpu_rdata);
            end
        end
        data_ok = 1'b0; cpu_hold = 1'b0;
        step();
        n_assert++;
        if ({req, cpu_stall} !== 2'b01) begin
            n_fail++; $display("FAIL hold_release: got req=%b stall=%b want 0/1", req, cpu_stall);
        end
        step();
        n_assert++;
        if (req !== 1'b1) begin n_fail++; $display("FAIL hold_reissue: got req=%b want 1", req); end
        cpu_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cpu_en = 1'b1; cpu_addr = 32'h80;
        step();
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0; cpu_en = 1'b0;
        #1;
        n_assert++;
        if ({req, cpu_stall} !== 2'b01) begin
            n_fail++; $display("FAIL mid_wait: got req=%b stall=%b want 0/1", req, cpu_stall);
        end
        resetn = 1'b0;
        step();
        resetn = 1'b1; rdata = 32'h7777_7777; data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        step();
        n_assert++;
        if ({req, cpu_stall, cpu_rdata} !== 34'd0) begin
            n_fail++; $display("FAIL mid_reset: got req=%b stall=%b rdata=%h want 0/0/0", req, cpu_stall, cpu_rdata);
        end
    endtask

    task automatic test_random();
        int nh, cy, ad, dd, exp_cy; logic [31:0] fa, fd, a, d, rd, m_rd; logic [1:0] fs; logic fw;
        logic [3:0] fe, w; bit st;
        apply_reset();
        m_rd = 32'd0;
        for (int i = 0; i < 40; i++) begin
            step();
            w = (POSTED || $urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            a = $urandom; d = $urandom; rd = $urandom;
            ad = int'($urandom_range(0, 3)); dd = int'($urandom_range(0, 4)) - 1;
            run_access(w, a, d, rd, ad, dd, nh, cy, fa, fd, fs, fw, fe, st);
            exp_cy = ad + 1 + (dd < 0 ? 1 : dd + 2);
            if (w == 4'd0) m_rd = rd;
            n_assert++;
            if ({fa, fs, fw, fe} !== {m_addr(w, a), m_size(w), w != 4'd0, w}) begin
                n_fail++; $display("FAIL rand_fields_%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                                   i, fa, fs, fw, fe, m_addr(w, a), m_size(w), w != 4'd0, w);
            end
            if (w != 4'd0) begin
                n_assert++;
                if (fd !== d) begin n_fail++; $display("FAIL rand_wdata_%0d: got %h want %h", i, fd, d); end
            end
            n_assert++;
            if (cy !== exp_cy || nh !== 1 || st !== 1'b1) begin
                n_fail++; $display("FAIL rand_timing_%0d: got lat=%0d hs=%0d stable=%b want %0d/1/1",
                                   i, cy, nh, st, exp_cy);
            end
            n_assert++;
            if (cpu_rdata !== m_rd) begin n_fail++; $display("FAIL rand_rdata_%0d: got %h want %h", i, cpu_rdata, m_rd); end
        end
    endtask

`ifdef CPU_SRAM2LIKE_POSTED_WR_EN
    task automatic test_posted();
        apply_reset();
        cpu_en = 1'b1; cpu_wen = 4'b1111; cpu_addr = 32'h100; cpu_wdata = 32'h0123_4567;
        step();
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        n_assert++;
        if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL posted_stall: got %b want 0", cpu_stall); end
        cpu_wen = 4'd0; cpu_addr = 32'h200;
        for (int i = 0; i < 2; i++) begin
            step();
            n_assert++;
            if ({req, cpu_stall} !== 2'b01) begin
                n_fail++; $display("FAIL posted_block_%0d: got req=%b stall=%b want 0/1", i, req, cpu_stall);
            end
        end
        data_ok = 1'b1; rdata = 32'h0;
        step();
        data_ok = 1'b0;
        n_assert++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL posted_early: got req=%b want 0", req); end
        step();
        n_assert++;
        if ({req, addr} !== {1'b1, 32'h200}) begin
            n_fail++; $display("FAIL posted_read_req: got req=%b addr=%h want 1/00000200", req, addr);
        end
        cpu_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_read_align();
        test_write_sizes();
        test_addr_ok_delay();
        test_same_cycle();
        test_hold();
        test_reset_mid();
        test_random();
`ifdef CPU_SRAM2LIKE_POSTED_WR_EN
        test_posted();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
